// File: rtl/axi_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_tb_pkg
// Brief    : Shared AXI burst encodings, sequencer state and 4 KB page size.
// Revision : 1.0
// ============================================================================
package axi_tb_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam int unsigned AXI_4KB_BOUNDARY = 4096;

    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_BURST = 1'b1
    } seq_state_e;

    // Wrapping bursts must span 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_next_addr.sv
`default_nettype none
// ============================================================================
// Module   : axi_next_addr
// Brief    : Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Revision : 1.0
// ============================================================================
module axi_next_addr
    import axi_tb_pkg::*;
#(
    parameter int ADDR_BITWIDTH = 32
) (
    input  logic [ADDR_BITWIDTH-1:0] i_addr,
    input  logic [2:0]               i_size,
    input  logic [7:0]               i_len,
    input  logic [1:0]               i_burst,
    input  logic [ADDR_BITWIDTH-1:0] i_wrap_base,
    output logic [ADDR_BITWIDTH-1:0] o_next_addr
);

    localparam logic [ADDR_BITWIDTH-1:0] c_one = ADDR_BITWIDTH'(1);

    logic [ADDR_BITWIDTH-1:0] w_bytes;
    logic [ADDR_BITWIDTH-1:0] w_aligned;
    logic [ADDR_BITWIDTH-1:0] w_incr;
    logic [ADDR_BITWIDTH-1:0] w_span;
    logic [ADDR_BITWIDTH-1:0] w_wrap_end;

    assign w_bytes    = c_one << i_size;
    assign w_aligned  = i_addr & ~(w_bytes - c_one);
    assign w_incr     = w_aligned + w_bytes;
    assign w_span     = w_bytes * ADDR_BITWIDTH'({1'b0, i_len} + 9'd1);
    assign w_wrap_end = i_wrap_base + w_span;

    // Reserved encoding falls through to INCR behaviour.
    always_comb begin
        o_next_addr = w_incr;
        if (i_burst == AXI_BURST_FIXED) begin
            o_next_addr = i_addr;
        end else if (i_burst == AXI_BURST_WRAP) begin
            o_next_addr = (w_incr == w_wrap_end) ? i_wrap_base : w_incr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_sequencer
// Brief    : Pops AXI address commands and walks each burst beat by beat.
//            Optional protocol checking: AXI_BURST_SEQ_PROTOCOL_CHECK_EN.
// Revision : 1.0
// ============================================================================
module axi_burst_sequencer
    import axi_tb_pkg::*;
#(
    parameter int ADDR_BITWIDTH = 32,
    parameter int ID_BITWIDTH   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_empty,
    output logic                     cmd_read,
    input  logic [ADDR_BITWIDTH-1:0] cmd_addr,
    input  logic [ID_BITWIDTH-1:0]   cmd_id,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [1:0]               cmd_burst,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ADDR_BITWIDTH-1:0] beat_addr,
    output logic [ID_BITWIDTH-1:0]   beat_id,
    output logic [7:0]               beat_idx,
    output logic                     beat_last,
    output logic                     busy,
    output logic                     prot_err
);

    localparam logic [ADDR_BITWIDTH-1:0] c_one = ADDR_BITWIDTH'(1);

    seq_state_e               r_state;
    seq_state_e               w_next_state;
    logic                     w_pop;
    logic [ADDR_BITWIDTH-1:0] r_addr;
    logic [ID_BITWIDTH-1:0]   r_id;
    logic [7:0]               r_idx;
    logic [7:0]               r_len;
    logic [2:0]               r_size;
    logic [1:0]               r_burst;
    logic [ADDR_BITWIDTH-1:0] r_wrap_base;
    logic [ADDR_BITWIDTH-1:0] w_next_addr;
    logic                     w_is_last;
    logic                     w_handshake;
    logic [ADDR_BITWIDTH-1:0] w_cap_bytes;
    logic [ADDR_BITWIDTH-1:0] w_cap_span;
    logic [ADDR_BITWIDTH-1:0] w_cap_base;

    assign w_is_last   = (r_idx == r_len);
    assign w_handshake = (r_state == SEQ_BURST) && beat_ready;

    assign w_cap_bytes = c_one << cmd_size;
    assign w_cap_span  = w_cap_bytes * ADDR_BITWIDTH'({1'b0, cmd_len} + 9'd1);
    assign w_cap_base  = cmd_addr & ~(w_cap_span - c_one);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A pop on the last handshake chains the next burst with no idle cycle.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        if (r_state == SEQ_IDLE) begin
            if (!cmd_empty) begin
                w_pop        = 1'b1;
                w_next_state = SEQ_BURST;
            end
        end else if (w_handshake && w_is_last) begin
            if (!cmd_empty) begin
                w_pop = 1'b1;
            end else begin
                w_next_state = SEQ_IDLE;
            end
        end
        if (reset) begin
            w_pop = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_id        <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_wrap_base <= '0;
        end else if (w_pop) begin
            r_addr      <= cmd_addr;
            r_id        <= cmd_id;
            r_idx       <= '0;
            r_len       <= cmd_len;
            r_size      <= cmd_size;
            r_burst     <= cmd_burst;
            r_wrap_base <= w_cap_base;
        end else if (w_handshake && !w_is_last) begin
            r_idx  <= r_idx + 8'd1;
            r_addr <= w_next_addr;
        end
    end

    axi_next_addr #(
        .ADDR_BITWIDTH (ADDR_BITWIDTH)
    ) u_next_addr (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .i_wrap_base (r_wrap_base),
        .o_next_addr (w_next_addr)
    );

`ifdef AXI_BURST_SEQ_PROTOCOL_CHECK_EN
    localparam logic [ADDR_BITWIDTH-1:0] c_page_mask =
        ~(ADDR_BITWIDTH'(AXI_4KB_BOUNDARY) - c_one);

    logic [ADDR_BITWIDTH-1:0] w_last_byte;
    logic                     w_cross_4k;
    logic                     w_wrap_bad;
    logic                     w_violation;
    logic                     r_prot_err;

    assign w_last_byte = cmd_addr + w_cap_span - c_one;
    assign w_cross_4k  = (cmd_addr & c_page_mask) != (w_last_byte & c_page_mask);
    assign w_wrap_bad  = !wrap_len_legal(cmd_len) || (|(cmd_addr & (w_cap_bytes - c_one)));
    assign w_violation = (cmd_burst == 2'b11)
                       || ((cmd_burst == AXI_BURST_WRAP) && w_wrap_bad)
                       || ((cmd_burst == AXI_BURST_INCR) && w_cross_4k);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prot_err <= 1'b0;
        end else if (w_pop && w_violation) begin
            r_prot_err <= 1'b1;
        end
    end

    assign prot_err = r_prot_err;
`else
    assign prot_err = 1'b0;
`endif

    assign cmd_read   = w_pop;
    assign busy       = (r_state == SEQ_BURST);
    assign beat_valid = busy;
    assign beat_addr  = r_addr;
    assign beat_id    = r_id;
    assign beat_idx   = r_idx;
    assign beat_last  = busy && w_is_last;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_sequencer
// Brief    : Directed self-checking bench for axi_burst_sequencer.
// Revision : 1.0
// ============================================================================
module tb_axi_burst_sequencer;

`ifdef AXI_BURST_SEQ_PROTOCOL_CHECK_EN
    localparam logic c_exp_err = 1'b1;
`else
    localparam logic c_exp_err = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cmd_empty;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [0:0]  cmd_id;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [0:0]  beat_id;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        busy;
    logic        prot_err;

    int checks = 0;
    int errors = 0;

    axi_burst_sequencer #(
        .ADDR_BITWIDTH (32),
        .ID_BITWIDTH   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_empty  (cmd_empty),
        .cmd_read   (cmd_read),
        .cmd_addr   (cmd_addr),
        .cmd_id     (cmd_id),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_id    (beat_id),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .busy       (busy),
        .prot_err   (prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] addr, input logic id,
                            input int idx, input logic last, input logic rd);
        chk({tag, "_valid"}, beat_valid, 1'b1);
        chk({tag, "_addr"},  beat_addr,  addr);
        chk({tag, "_id"},    beat_id,    id);
        chk({tag, "_idx"},   beat_idx,   idx[7:0]);
        chk({tag, "_last"},  beat_last,  last);
        chk({tag, "_read"},  cmd_read,   rd);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, beat_valid, 1'b0);
        chk({tag, "_busy"},  busy,       1'b0);
        chk({tag, "_addr"},  beat_addr,  32'h0);
        chk({tag, "_id"},    beat_id,    1'b0);
        chk({tag, "_idx"},   beat_idx,   8'h0);
        chk({tag, "_last"},  beat_last,  1'b0);
        chk({tag, "_perr"},  prot_err,   1'b0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_cmd(input logic [31:0] addr, input logic id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        cmd_addr  = addr;
        cmd_id    = id;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_empty = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_empty = 1'b1; beat_ready = 1'b0;
        cmd_addr = '0; cmd_id = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        tick(); tick();
        // Pending command during reset must not be popped
        tick(); load_cmd(32'h1000, 1'b1, 8'd3, 3'd2, 2'b01); #1;
        chk("rst_read", cmd_read, 1'b0);
        chk_idle("rst");
        tick(); reset = 1'b0; cmd_empty = 1'b1; #1;
        chk_idle("rst_out");
        chk("rst_out_read", cmd_read, 1'b0);

        // 1: INCR 0x1000 LEN3 SIZE2
        tick(); load_cmd(32'h1000, 1'b1, 8'd3, 3'd2, 2'b01); beat_ready = 1'b1; #1;
        chk("t1_pop", cmd_read, 1'b1);
        chk("t1_pop_valid", beat_valid, 1'b0);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t1_b0", 32'h1000, 1'b1, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t1_b1", 32'h1004, 1'b1, 1, 1'b0, 1'b0);
        tick(); #1; chk_beat("t1_b2", 32'h1008, 1'b1, 2, 1'b0, 1'b0);
        tick(); #1; chk_beat("t1_b3", 32'h100C, 1'b1, 3, 1'b1, 1'b0);
        tick(); #1; chk("t1_done_busy", busy, 1'b0); chk("t1_done_valid", beat_valid, 1'b0);

        // 2: WRAP 0x1038 LEN3 SIZE3, wraps at 0x1040 to base 0x1020
        tick(); load_cmd(32'h1038, 1'b0, 8'd3, 3'd3, 2'b10); #1;
        chk("t2_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t2_b0", 32'h1038, 1'b0, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t2_b1", 32'h1020, 1'b0, 1, 1'b0, 1'b0);
        tick(); #1; chk_beat("t2_b2", 32'h1028, 1'b0, 2, 1'b0, 1'b0);
        tick(); #1; chk_beat("t2_b3", 32'h1030, 1'b0, 3, 1'b1, 1'b0);
        tick(); #1; chk("t2_done_busy", busy, 1'b0);

        // 3a: FIXED 0x2000 LEN2
        tick(); load_cmd(32'h2000, 1'b1, 8'd2, 3'd2, 2'b00); #1;
        chk("t3a_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t3a_b0", 32'h2000, 1'b1, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t3a_b1", 32'h2000, 1'b1, 1, 1'b0, 1'b0);
        tick(); #1; chk_beat("t3a_b2", 32'h2000, 1'b1, 2, 1'b1, 1'b0);
        tick(); #1; chk("t3a_done_busy", busy, 1'b0);

        // 3b: unaligned INCR 0x3003 SIZE2 aligns on the second beat
        tick(); load_cmd(32'h3003, 1'b0, 8'd2, 3'd2, 2'b01); #1;
        chk("t3b_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t3b_b0", 32'h3003, 1'b0, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t3b_b1", 32'h3004, 1'b0, 1, 1'b0, 1'b0);
        tick(); #1; chk_beat("t3b_b2", 32'h3008, 1'b0, 2, 1'b1, 1'b0);
        tick(); #1; chk("t3b_done_busy", busy, 1'b0);

        // 4a: back-to-back LEN1 then LEN0, no bubble
        tick(); load_cmd(32'h4000, 1'b1, 8'd1, 3'd2, 2'b01); #1;
        chk("t4a_pop0", cmd_read, 1'b1);
        tick(); load_cmd(32'h5000, 1'b0, 8'd0, 3'd2, 2'b01); #1;
        chk_beat("t4a_b0", 32'h4000, 1'b1, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t4a_b1", 32'h4004, 1'b1, 1, 1'b1, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t4a_b2", 32'h5000, 1'b0, 0, 1'b1, 1'b0);
        tick(); #1; chk("t4a_done_busy", busy, 1'b0);

        // 4b: stalls hold the beat outputs
        tick(); load_cmd(32'h6000, 1'b1, 8'd1, 3'd2, 2'b01); beat_ready = 1'b0; #1;
        chk("t4b_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t4b_s0", 32'h6000, 1'b1, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t4b_s1", 32'h6000, 1'b1, 0, 1'b0, 1'b0);
        tick(); beat_ready = 1'b1; #1; chk_beat("t4b_s2", 32'h6000, 1'b1, 0, 1'b0, 1'b0);
        tick(); beat_ready = 1'b0; #1; chk_beat("t4b_s3", 32'h6004, 1'b1, 1, 1'b1, 1'b0);
        tick(); #1; chk_beat("t4b_s4", 32'h6004, 1'b1, 1, 1'b1, 1'b0);
        tick(); beat_ready = 1'b1; #1; chk_beat("t4b_s5", 32'h6004, 1'b1, 1, 1'b1, 1'b0);
        tick(); #1; chk("t4b_done_busy", busy, 1'b0);
        tick(); #1; chk("t4b_idle_ready_busy", busy, 1'b0);
        chk("t4b_idle_ready_idx", beat_idx, 8'd1);

        // 5: reset at idx 2 of a LEN7 burst
        tick(); load_cmd(32'h7000, 1'b1, 8'd7, 3'd2, 2'b01); #1;
        chk("t5_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t5_b0", 32'h7000, 1'b1, 0, 1'b0, 1'b0);
        tick(); #1; chk_beat("t5_b1", 32'h7004, 1'b1, 1, 1'b0, 1'b0);
        tick(); reset = 1'b1; load_cmd(32'hA000, 1'b1, 8'd0, 3'd2, 2'b01); #1;
        chk_beat("t5_b2", 32'h7008, 1'b1, 2, 1'b0, 1'b0);
        tick(); reset = 1'b0; cmd_empty = 1'b1; #1;
        chk_idle("t5_rst");
        chk("t5_rst_read", cmd_read, 1'b0);
        tick(); load_cmd(32'h8000, 1'b0, 8'd0, 3'd2, 2'b01); #1;
        chk("t5_new_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t5_new_b0", 32'h8000, 1'b0, 0, 1'b1, 1'b0);
        tick(); #1; chk("t5_new_done_busy", busy, 1'b0);
        chk("t5_clean_perr", prot_err, 1'b0);

        // 6a: WRAP with illegal LEN2
        tick(); load_cmd(32'h9000, 1'b1, 8'd2, 3'd2, 2'b10); #1;
        chk("t6a_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t6a_b0", 32'h9000, 1'b1, 0, 1'b0, 1'b0);
        chk("t6a_perr", prot_err, c_exp_err);
        tick(); #1; chk_beat("t6a_b1", 32'h9004, 1'b1, 1, 1'b0, 1'b0);
        tick(); #1; chk_beat("t6a_b2", 32'h9008, 1'b1, 2, 1'b1, 1'b0);
        tick(); #1; chk("t6a_done_busy", busy, 1'b0);
        chk("t6a_perr_held", prot_err, c_exp_err);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("t6a_perr_clr", prot_err, 1'b0);

        // 6b: INCR 0x0FF0 LEN7 SIZE2 crosses 0x1000
        tick(); load_cmd(32'h0FF0, 1'b0, 8'd7, 3'd2, 2'b01); #1;
        chk("t6b_pop", cmd_read, 1'b1);
        tick(); cmd_empty = 1'b1; #1; chk_beat("t6b_b0", 32'h0FF0, 1'b0, 0, 1'b0, 1'b0);
        chk("t6b_perr", prot_err, c_exp_err);
        for (int i = 1; i < 8; i++) begin
            tick(); #1;
            chk_beat("t6b_bn", 32'h0FF0 + 32'(4 * i), 1'b0, i, (i == 7), 1'b0);
        end
        tick(); #1; chk("t6b_done_busy", busy, 1'b0);
        chk("t6b_perr_held", prot_err, c_exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
